// File: rtl/memstream_axis_if.sv
// AXI-Stream bundle carried between the memstream RAM reader and its consumer.
interface memstream_axis_if #(
    parameter int DWIDTH = 18
);
    logic [DWIDTH-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/memstream_ram_reader.sv
// Streams a block-RAM region out as AXI-Stream with credit-based read issue.
// Optional macro MEMSTREAM_LOOP_EN: wrap and replay the region forever after one start.
module memstream_ram_reader_chk #(
    parameter int CW         = 3,
    parameter int FIFO_DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    input logic          push,
    input logic          pop,
    input logic [CW-1:0] count
);
    // Every returning read must find a free slot reserved by the issue credit.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count == CW'(FIFO_DEPTH))));
endmodule

module memstream_ram_reader #(
    parameter int DWIDTH     = 18,
    parameter int AWIDTH     = 10,
    parameter int START_ADDR = 0,
    parameter int NWORDS     = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [AWIDTH-1:0]  ram_addr,
    input  logic [DWIDTH-1:0]  ram_rdq,
    memstream_axis_if.master   m_axis
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 3);
    localparam logic [AWIDTH-1:0] FIRST_ADDR = AWIDTH'(START_ADDR);
    localparam logic [AWIDTH-1:0] END_ADDR   = AWIDTH'(START_ADDR + NWORDS - 1);

    logic [1:0]        state_r;
    logic [AWIDTH-1:0] addr_r;
    logic              busy_r;
    logic              done_r;
    logic              s1_v_r;
    logic              s1_last_r;
    logic              s2_v_r;
    logic              s2_last_r;
    logic [DWIDTH:0]   fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;

    logic              issue_s;
    logic              push_s;
    logic              pop_s;
    logic              last_addr_s;
    logic              last_beat_s;
    logic              valid_s;
    logic [CW-1:0]     credit_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(FIFO_DEPTH - 1)) begin
            ptr_inc = {PW{1'b0}};
        end else begin
            ptr_inc = p + PW'(1);
        end
    endfunction

    // Issue credit counts buffered words plus both in-flight reads; same-cycle pops earn nothing.
    always_comb begin
        credit_s    = count_r + CW'(s1_v_r) + CW'(s2_v_r);
        last_addr_s = (addr_r == END_ADDR);
        valid_s     = (count_r != {CW{1'b0}});
        push_s      = s2_v_r;
        pop_s       = valid_s && m_axis.tready;
        last_beat_s = pop_s && fifo_mem_r[rd_ptr_r][DWIDTH];
        if (state_r == ST_RUN) begin
            issue_s = (credit_s < CW'(FIFO_DEPTH));
        end else begin
            issue_s = 1'b0;
        end
    end

    assign ram_addr      = addr_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign m_axis.tvalid = valid_s;
    assign m_axis.tdata  = fifo_mem_r[rd_ptr_r][DWIDTH-1:0];
    assign m_axis.tlast  = valid_s && fifo_mem_r[rd_ptr_r][DWIDTH];

    // Pass control: address walk, busy/done and state transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            addr_r  <= FIRST_ADDR;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= last_beat_s;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_RUN;
                        addr_r  <= FIRST_ADDR;
                        busy_r  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (issue_s) begin
                        if (last_addr_s) begin
`ifdef MEMSTREAM_LOOP_EN
                            addr_r <= FIRST_ADDR;
`else
                            state_r <= ST_DRAIN;
`endif
                        end else begin
                            addr_r <= addr_r + AWIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (last_beat_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Two-stage issue tracker matching the RAM read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_r    <= 1'b0;
            s1_last_r <= 1'b0;
            s2_v_r    <= 1'b0;
            s2_last_r <= 1'b0;
        end else begin
            s1_v_r    <= issue_s;
            s1_last_r <= issue_s && last_addr_s;
            s2_v_r    <= s1_v_r;
            s2_last_r <= s1_last_r;
        end
    end

    // Output FIFO holding {last, data}; the head drives the stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= {(DWIDTH + 1){1'b0}};
            end
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {s2_last_r, ram_rdq};
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    memstream_ram_reader_chk #(.CW(CW), .FIFO_DEPTH(FIFO_DEPTH)) u_chk (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .count (count_r)
    );
endmodule
